// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both
// sides and an architectural NZCV flag register that updates at retire.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds its payload stable while valid is high and
// ready is low. in_ready depends only on reset, out_ready and the internal
// valid bits, never on in_valid.
//
// Optional feature: define ALU_PIPE_SHIFT_EN to enable cntrl 001 (logical
// shift left) and 111 (logical shift right). Without it, both opcodes
// behave as unused opcodes.

module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
`ifdef ALU_PIPE_SHIFT_EN
    localparam logic [2:0] OP_SLL   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b111;
`endif

    // Stage 1: captured operands and control
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;
    logic             s1_setf_q;

    // Stage 2: computed result and per-result flags
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic             s2_n_q;
    logic             s2_z_q;
    logic             s2_v_q;
    logic             s2_c_q;
    logic             s2_setf_q;

    // Architectural flag register
    logic             fn_q;
    logic             fz_q;
    logic             fv_q;
    logic             fc_q;

    // ALU next-state values feeding stage 2
    logic [WIDTH-1:0] res_d;
    logic             n_d;
    logic             z_d;
    logic             v_d;
    logic             c_d;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    logic s2_load;
    logic s1_load;
    logic in_fire;
    logic out_fire;

    // Pipeline advance: stage 2 moves when empty or drained; stage 1 moves
    // when empty or when its content is moving into stage 2.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = !reset && s1_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // Combinational ALU on the stage-1 contents
    always_comb begin
        res_d = '0;
        v_d   = 1'b0;
        c_d   = 1'b0;
        // Subtract reuses the adder as A + ~B + 1; carry is then "no borrow".
        b_eff = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
        sum   = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (s1_op_q == OP_SUB)};
        case (s1_op_q)
            OP_PASSB: res_d = s1_b_q;
            OP_ADD, OP_SUB: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND:   res_d = s1_a_q & s1_b_q;
            OP_OR:    res_d = s1_a_q | s1_b_q;
            OP_XOR:   res_d = s1_a_q ^ s1_b_q;
`ifdef ALU_PIPE_SHIFT_EN
            OP_SLL:   res_d = s1_a_q << s1_b_q[SHW-1:0];
            OP_SRL:   res_d = s1_a_q >> s1_b_q[SHW-1:0];
`endif
            default:  res_d = '0;
        endcase
        n_d = res_d[WIDTH-1];
        z_d = (res_d == '0);
    end

    // Stage 1 register: accept a new operation whenever stage 1 can load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_setf_q  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_a_q    <= A;
                s1_b_q    <= B;
                s1_op_q   <= cntrl;
                s1_setf_q <= set_flags;
            end
        end
    end

    // Stage 2 register: holds result and flags stable while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_n_q     <= 1'b0;
            s2_z_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_c_q     <= 1'b0;
            s2_setf_q  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q  <= res_d;
                s2_n_q    <= n_d;
                s2_z_q    <= z_d;
                s2_v_q    <= v_d;
                s2_c_q    <= c_d;
                s2_setf_q <= s1_setf_q;
            end
        end
    end

    // Flag register: updates in program order when a flag-setting op retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fn_q <= 1'b0;
            fz_q <= 1'b0;
            fv_q <= 1'b0;
            fc_q <= 1'b0;
        end else if (out_fire && s2_setf_q) begin
            fn_q <= s2_n_q;
            fz_q <= s2_z_q;
            fv_q <= s2_v_q;
            fc_q <= s2_c_q;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign negative  = s2_n_q;
    assign zero      = s2_z_q;
    assign overflow  = s2_v_q;
    assign carry_out = s2_c_q;
    assign flag_n    = fn_q;
    assign flag_z    = fz_q;
    assign flag_v    = fv_q;
    assign flag_c    = fc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH = 64): directed steps plus random
// streaming, checked against a behavioural model and an expected queue.
module tb_alu_pipe;

    localparam int WIDTH = 64;
    localparam int EW    = WIDTH + 5;   // {set_flags, n, z, v, c, result}

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative, zero, overflow, carry_out;
    logic             flag_n, flag_z, flag_v, flag_c;

    int checks     = 0;
    int errors     = 0;
    int retire_cnt = 0;

    logic [EW-1:0] exp_q[$];
    logic [3:0]    model_flags = 4'b0000;   // {n, z, v, c}

    // Clock and DUT
    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_c    (flag_c)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: signed/unsigned arithmetic on whole values
    function automatic logic [WIDTH+3:0] ref_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        logic [WIDTH-1:0] r;
        logic             v, c;
        longint           sa, sb, sr;
        sa = $signed(a);
        sb = $signed(b);
        sr = 0;
        r  = '0;
        v  = 1'b0;
        c  = 1'b0;
        case (op)
            3'd0: r = b;
            3'd2: begin
                r  = a + b;
                sr = $signed(r);
                c  = (r < a);
                v  = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
            end
            3'd3: begin
                r  = a - b;
                sr = $signed(r);
                c  = (a >= b);
                v  = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
`ifdef ALU_PIPE_SHIFT_EN
            3'd1: r = a << b[5:0];
            3'd7: r = a >> b[5:0];
`endif
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == '0), v, c, r};
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: sample mid-cycle, check outputs and flag register, track fires
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_result", result, 0);
            check("rst_flags", {flag_n, flag_z, flag_v, flag_c, negative, zero, overflow, carry_out}, 0);
            exp_q.delete();
            model_flags = 4'b0000;
        end else begin
            check("flag_reg", {flag_n, flag_z, flag_v, flag_c}, model_flags);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check("result_flags", {negative, zero, overflow, carry_out, result},
                          exp_q[0][WIDTH+3:0]);
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        if (e[WIDTH+4]) model_flags = e[WIDTH+3:WIDTH];
                        retire_cnt++;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({set_flags, ref_op(A, B, cntrl)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Directed sequence
    initial begin
        int               rv0;
        int               ov;
        logic [WIDTH-1:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        cntrl     = 3'd0;
        set_flags = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // ADD max+max, set flags
        A = 64'h7FFF_FFFF_FFFF_FFFF;
        B = 64'h7FFF_FFFF_FFFF_FFFF;
        cntrl = 3'b010; set_flags = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("add_not_early", out_valid, 0);
        step();
        check("add_out_valid", out_valid, 1);
        check("add_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_overflow", overflow, 1);
        check("add_negative", negative, 1);
        check("add_carry", carry_out, 0);
        step();
        check("add_flag_v", flag_v, 1);
        check("add_flag_n", flag_n, 1);
        check("add_drained", out_valid, 0);

        // SUB 5-5 without flag update
        A = 64'd5; B = 64'd5; cntrl = 3'b011; set_flags = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("sub_out_valid", out_valid, 1);
        check("sub_result", result, 0);
        check("sub_zero", zero, 1);
        check("sub_carry", carry_out, 1);
        step();
        check("sub_flags_held", {flag_n, flag_z, flag_v, flag_c}, 4'b1010);

        // Random stream at full throughput
        rv0 = retire_cnt;
        ov  = 0;
        for (int i = 0; i < 100; i++) begin
            A = pick(); B = pick();
            cntrl = 3'($urandom_range(0, 7));
            set_flags = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            step();
            if (i >= 1 && out_valid) ov++;
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("stream_one_per_cycle", ov, 99);
        check("stream_retired", retire_cnt - rv0, 100);

        // Fill pipeline and stall output for 5 cycles
        rv0 = retire_cnt;
        out_ready = 1'b0;
        A = pick(); B = pick(); cntrl = 3'b010; set_flags = 1'b1; in_valid = 1'b1;
        step();
        A = pick(); B = pick(); cntrl = 3'b011; set_flags = 1'b1;
        step();
        A = pick(); B = pick(); cntrl = 3'b110; set_flags = 1'b0;
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        held = result;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_hold_in_ready", in_ready, 0);
            check("stall_hold_result", result, held);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("stall_drain_count", retire_cnt - rv0, 3);
        check("stall_queue_empty", exp_q.size(), 0);

        // Set a flag, then reset with two ops in flight
        A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'h1; cntrl = 3'b010; set_flags = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("pre_reset_flag_v", flag_v, 1);
        A = pick(); B = pick(); cntrl = 3'b100; set_flags = 1'b1; in_valid = 1'b1;
        step();
        A = pick(); B = pick(); cntrl = 3'b101;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_flags", {flag_n, flag_z, flag_v, flag_c}, 0);
        step();
        reset = 1'b0;
        rv0 = retire_cnt;
        repeat (4) step();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_no_retire", retire_cnt - rv0, 0);

        // Shift-left opcode
        A = 64'd1; B = 64'd63; cntrl = 3'b001; set_flags = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("sll_out_valid", out_valid, 1);
`ifdef ALU_PIPE_SHIFT_EN
        check("sll_result", result, 64'h8000_0000_0000_0000);
        check("sll_negative", negative, 1);
`else
        check("op001_result", result, 0);
        check("op001_zero", zero, 1);
`endif
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
